// File: rtl/sad_best_select_pkg.sv
// Shared motion-estimation definitions: AD width, derived widths, FSM states.
package sad_best_select_pkg;

    localparam int ME_AD_W = 8;

    function automatic int sad_w(input int n_pe, input int ad_w, input int blk_h);
        return ad_w + $clog2(n_pe) + $clog2(blk_h);
    endfunction

    function automatic int idx_w(input int n_cand);
        return (n_cand > 1) ? $clog2(n_cand) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/sad_best_select_ad_row_sum.sv
// Stage 1: reduces one AD row to its unsigned sum, registered with valid/last.
module ad_row_sum #(
    parameter int N_PE = 16,
    parameter int AD_W = 8,
    localparam int SUM_W = AD_W + $clog2(N_PE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [N_PE*AD_W-1:0] ad_bus,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SUM_W-1:0]     sum
);

    logic [SUM_W-1:0] tree;

    always_comb begin
        tree = '0;
        for (int i = 0; i < N_PE; i++) begin
            tree = tree + SUM_W'(ad_bus[i*AD_W +: AD_W]);
        end
    end

    // Data holds across bubbles; only the valid bit advances.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= tree;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/sad_best_select.sv
// Accumulates per-candidate SAD from AD rows and reports the best candidate
// of each search window.
module sad_best_select
    import sad_best_select_pkg::*;
#(
    parameter int N_PE   = 16,
    parameter int AD_W   = ME_AD_W,
    parameter int BLK_H  = 16,
    parameter int N_CAND = 289,
    parameter int IDX_W  = idx_w(N_CAND),
    parameter int SAD_W  = sad_w(N_PE, AD_W, BLK_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_start,
    input  logic                 ad_valid,
    input  logic [N_PE*AD_W-1:0] ad_bus,
    output logic                 busy,
    output logic                 result_valid,
    output logic [SAD_W-1:0]     best_sad,
    output logic [IDX_W-1:0]     best_idx
);

    localparam int RS_W  = AD_W + $clog2(N_PE);
    localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(N_CAND - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(BLK_H - 1);

    state_t           state;
    logic [ROW_W-1:0] row_cnt;
    logic [IDX_W-1:0] in_cand;
    logic [IDX_W-1:0] cand_cnt;
    logic [IDX_W-1:0] cand_i;
    logic [IDX_W-1:0] best_i;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] cand_sad;
    logic [SAD_W-1:0] best;
    logic             cand_valid;
    logic [1:0]       drain;

    logic             accept;
    logic             row_last;
    logic             s1_valid;
    logic             s1_last;
    logic [RS_W-1:0]  s1_sum;

    // A start pulse always wins over a row presented in the same cycle.
    assign accept   = (state == ACCUM) && ad_valid && !blk_start;
    assign row_last = (row_cnt == LAST_ROW);

    ad_row_sum #(
        .N_PE (N_PE),
        .AD_W (AD_W)
    ) u_row_sum (
        .clk       (clk),
        .rst       (rst),
        .flush     (blk_start),
        .in_valid  (accept),
        .in_last   (row_last),
        .ad_bus    (ad_bus),
        .out_valid (s1_valid),
        .out_last  (s1_last),
        .sum       (s1_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            best_sad     <= '0;
            best_idx     <= '0;
            row_cnt      <= '0;
            in_cand      <= '0;
            cand_cnt     <= '0;
            cand_i       <= '0;
            best_i       <= '0;
            acc          <= '0;
            cand_sad     <= '0;
            best         <= '0;
            cand_valid   <= 1'b0;
            drain        <= '0;
        end else begin
            result_valid <= 1'b0;
            if (blk_start) begin
                state      <= ACCUM;
                busy       <= 1'b1;
                row_cnt    <= '0;
                in_cand    <= '0;
                cand_cnt   <= '0;
                acc        <= '0;
                cand_valid <= 1'b0;
                best       <= '1;
                best_i     <= '0;
                drain      <= '0;
            end else begin
                if (accept) begin
                    row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
                    if (row_last) begin
                        in_cand <= (in_cand == LAST_CAND) ? '0 : in_cand + IDX_W'(1);
                        if (in_cand == LAST_CAND) begin
                            state <= DONE;
                            drain <= '0;
                        end
                    end
                end

                // Stage 2: candidate accumulation
                cand_valid <= s1_valid && s1_last;
                if (s1_valid) begin
                    if (s1_last) begin
                        cand_sad <= acc + SAD_W'(s1_sum);
                        cand_i   <= cand_cnt;
                        acc      <= '0;
                        cand_cnt <= (cand_cnt == LAST_CAND) ? '0 : cand_cnt + IDX_W'(1);
                    end else begin
                        acc <= acc + SAD_W'(s1_sum);
                    end
                end

                // Stage 3: strict compare keeps the lower index on ties
                if (cand_valid && (cand_sad < best)) begin
                    best   <= cand_sad;
                    best_i <= cand_i;
                end

                if (state == DONE) begin
                    drain <= drain + 2'd1;
                    if (drain == 2'd2) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        best_sad     <= best;
                        best_idx     <= best_i;
                    end
                end
            end
        end
    end

endmodule
